uart_frame_loader: RTL
======================

Name: uart_frame_loader

Overview:
- Sits between the UART byte receiver and the dual-port image BRAM write port.
- Replaces free-running address counting with framed image loading.
- Hunts for a 2-byte sync header, then writes exactly FRAME_PIXELS payload bytes to sequential addresses from 0, then checks a trailing 8-bit checksum.
- Aborts cleanly on UART framing error or inter-byte timeout, so a corrupted or partial transfer never leaves the write address misaligned for the next frame.

Parameters:
FRAME_PIXELS, 307200, payload bytes per frame (one 8-bit pixel each)
ADDR_W, 19, BRAM write address width
SYNC0, 8'hAA, first header byte
SYNC1, 8'h55, second header byte
TIMEOUT_CYCLES, 5000000, max clk cycles between bytes once a frame has started (100 ms at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte, valid when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
rx_frame_error  in  1  one-cycle strobe: stop-bit error on current byte
wr_en  out  1  BRAM write enable
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  8  BRAM write data
frame_done  out  1  one-cycle pulse when a frame ends, checksum good or bad
frame_ok  out  1  level: last completed frame had a matching checksum
err_frame  out  1  sticky: frame aborted by rx_frame_error
err_timeout  out  1  sticky: frame aborted by inter-byte timeout
err_checksum  out  1  sticky: last frame's checksum mismatched
busy  out  1  high in SYNC, PAYLOAD or CHECK
state_dbg  out  2  current state encoding: IDLE=0, SYNC=1, PAYLOAD=2, CHECK=3
frame_count  out  8  count of good frames; wraps 255 to 0

Behaviour:
- Reset: every output is 0; state IDLE; pixel counter, running sum and timeout counter are 0.
- Reset wins over all other events. Reset mid-payload discards the partial frame with no error flag.
- All outputs are registered.
- A byte accepted in cycle N drives wr_en/wr_addr/wr_data in cycle N+1.
- wr_en is high for exactly one cycle per payload byte. wr_addr and wr_data hold their last values when wr_en=0.
- A byte is accepted when rx_valid=1 and rx_frame_error=0.
- If rx_valid and rx_frame_error are both high in the same cycle, the byte is discarded and treated as a framing error.

State transitions:
- IDLE:
  - accepted byte == SYNC0 -> SYNC.
  - other bytes ignored.
  - rx_frame_error ignored.
- SYNC:
  - byte == SYNC1 -> PAYLOAD; clear pixel counter, sum, and all three err_* flags.
  - byte == SYNC0 -> stay in SYNC (handles AA AA 55).
  - any other byte -> IDLE.
- PAYLOAD:
  - each accepted byte is written at address = pixel counter.
  - sum <= sum + byte, modulo 256.
  - pixel counter increments.
  - the byte with counter == FRAME_PIXELS-1 is written, then -> CHECK.
  - the counter never exceeds FRAME_PIXELS-1, so wr_addr never exceeds FRAME_PIXELS-1.
- CHECK:
  - next accepted byte is the checksum; it is not written.
  - frame_done pulses one cycle later.
  - frame_ok <= (byte == sum).
  - err_checksum <= (byte != sum).
  - frame_count increments on a match.
  - -> IDLE.

Abort conditions:
- rx_frame_error in SYNC, PAYLOAD or CHECK: err_frame <= 1 and -> IDLE. No frame_done; frame_ok unchanged; already-written bytes stay in BRAM.
- Timeout counter:
  - cleared on any rx_valid, and in IDLE.
  - increments every cycle in SYNC, PAYLOAD and CHECK.
  - on reaching TIMEOUT_CYCLES-1: err_timeout <= 1 and -> IDLE. No frame_done.
- Sticky error flags clear only on rst or on the next SYNC->PAYLOAD transition.
- busy = (state != IDLE).

Test Plan (FRAME_PIXELS=4, TIMEOUT_CYCLES=50 in sim):
- Send AA 55 10 20 30 40 A0 -> writes (0,10),(1,20),(2,30),(3,40) each one cycle after its rx_valid; frame_done pulse; frame_ok=1; frame_count=1; wr_en exactly 4 pulses.
- Send AA 55 01 02 03 04 00 -> 4 writes; frame_done pulse; frame_ok=0; err_checksum=1; frame_count unchanged. A following good frame clears err_checksum and sets frame_ok=1.
- Send 00 AA AA 55 then four 0x01 bytes, then checksum 04 -> first 00 ignored; double AA accepted; writes to addresses 0..3; frame_ok=1.
- Send AA 55 11 22, then hold rx_valid=0 for 50 cycles -> err_timeout=1, state_dbg=0, busy=0, no frame_done. Next full frame writes again from address 0.
- Send AA 55 11, then assert rx_valid and rx_frame_error together with byte 22 -> no write for 22; err_frame=1; return to IDLE. The next frame writes from address 0.
- Assert rst during payload after 2 writes -> all outputs 0 next cycle; no error flags set; the next frame starts at address 0.

Source files
------------

// File: rtl/uart_frame_loader.sv
// UART byte stream to BRAM loader: hunts a two-byte sync header, writes one
// frame of pixels from address 0, then checks a trailing 8-bit checksum.
module uart_frame_loader #(
  parameter int          FRAME_PIXELS   = 307200,
  parameter int          ADDR_W         = 19,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55,
  parameter int          TIMEOUT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_frame_error_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              frame_done_o,
  output logic              frame_ok_o,
  output logic              err_frame_o,
  output logic              err_timeout_o,
  output logic              err_checksum_o,
  output logic              busy_o,
  output logic [1:0]        state_dbg_o,
  output logic [7:0]        frame_count_o
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic              ef_q, ef_d;
  logic              et_q, et_d;
  logic              ec_q, ec_d;
  logic              busy_q, busy_d;
  logic [7:0]        cnt_q, cnt_d;

  logic acc;
  logic tmo_hit;
  logic active;

  assign acc     = rx_valid_i & ~rx_frame_error_i;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign active  = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    ef_d      = ef_q;
    et_d      = et_q;
    ec_d      = ec_q;
    cnt_d     = cnt_q;

    // Aborts take priority so a broken transfer never advances the address.
    if (active && rx_frame_error_i) begin
      ef_d    = 1'b1;
      state_d = IDLE;
    end else if (active && !rx_valid_i && tmo_hit) begin
      et_d    = 1'b1;
      state_d = IDLE;
    end else if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data_i == SYNC0) state_d = SYNC;
        end
        SYNC: begin
          if (rx_data_i == SYNC1) begin
            state_d = PAYLOAD;
            pix_d   = '0;
            sum_d   = '0;
            ef_d    = 1'b0;
            et_d    = 1'b0;
            ec_d    = 1'b0;
          end else if (rx_data_i != SYNC0) begin
            state_d = IDLE;
          end
        end
        PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_q;
          wr_data_d = rx_data_i;
          sum_d     = sum_q + rx_data_i;
          if (pix_q == ADDR_W'(FRAME_PIXELS - 1)) begin
            pix_d   = '0;
            state_d = CHECK;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
        CHECK: begin
          done_d  = 1'b1;
          ok_d    = (rx_data_i == sum_q);
          ec_d    = (rx_data_i != sum_q);
          if (rx_data_i == sum_q) cnt_d = cnt_q + 8'd1;
          state_d = IDLE;
        end
      endcase
    end

    if (state_d == IDLE || rx_valid_i) tmo_d = '0;
    else                               tmo_d = tmo_q + 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      ef_q      <= 1'b0;
      et_q      <= 1'b0;
      ec_q      <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      ef_q      <= ef_d;
      et_q      <= et_d;
      ec_q      <= ec_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign frame_done_o   = done_q;
  assign frame_ok_o     = ok_q;
  assign err_frame_o    = ef_q;
  assign err_timeout_o  = et_q;
  assign err_checksum_o = ec_q;
  assign busy_o         = busy_q;
  assign state_dbg_o    = state_q;
  assign frame_count_o  = cnt_q;

endmodule
